// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned REG_WIDTH  = 32;
  localparam int unsigned REG_DEPTH  = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_WIDTH-1:0]  reg_data_t;

  // Entry 0 is hard-wired to zero and can never be busy.
  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_busy_table.sv
// Per-register busy scoreboard: reserve/accept logic and a running busy count.
module regfile_busy_table
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH  = REG_DEPTH,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              rsv_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              wb_en,
  output logic              rsv_accept,
  output logic [DEPTH-1:0]  busy,
  output logic [ADDR_W:0]   busy_count
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] set_vec, clr_vec;
  logic [ADDR_W:0]  count_q, count_d;
  logic             set, clr, rsv_busy;

  // True for a writable, trackable entry (not the zero register, inside the array).
  function automatic logic real_reg(input logic [ADDR_W-1:0] a);
    return (a != ADDR_W'(ZERO_REG)) && (32'(a) < DEPTH);
  endfunction

  // Grant against registered busy state only; same-cycle writeback is not bypassed.
  always_comb begin
    set_vec    = '0;
    clr_vec    = '0;
    set        = 1'b0;
    clr        = 1'b0;
    rsv_busy   = real_reg(rsv_addr) ? busy_q[rsv_addr] : 1'b0;
    rsv_accept = rsv_req & ~rsv_busy;
    if (rsv_accept && real_reg(rsv_addr)) begin
      set_vec[rsv_addr] = 1'b1;
      set               = 1'b1;
    end
    // An accepted reserve implies the entry was idle, so set and clear never hit the same bit.
    if (wb_en && real_reg(wb_addr) && busy_q[wb_addr]) begin
      clr_vec[wb_addr] = 1'b1;
      clr              = 1'b1;
    end
    busy_d  = (busy_q & ~clr_vec) | set_vec;
    count_d = count_q + (ADDR_W+1)'(set) - (ADDR_W+1)'(clr);
  end

  // Busy vector and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy       = busy_q;
  assign busy_count = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with busy scoreboard and NREAD asynchronous read ports.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = REG_WIDTH,
  parameter int unsigned DEPTH  = REG_DEPTH,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned NREAD  = 2
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NREAD*ADDR_W-1:0] ReadRegister,
  output logic [NREAD*WIDTH-1:0]  ReadData,
  output logic [NREAD-1:0]        ReadBusy,
  input  logic [ADDR_W-1:0]       WriteRegister,
  input  logic [WIDTH-1:0]        WriteData,
  input  logic                    RegWrite,
  input  logic [ADDR_W-1:0]       ReserveRegister,
  input  logic                    Reserve,
  output logic                    ReserveAccept,
  output logic [ADDR_W:0]         BusyCount
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] busy;

  function automatic logic real_reg(input logic [ADDR_W-1:0] a);
    return (a != ADDR_W'(ZERO_REG)) && (32'(a) < DEPTH);
  endfunction

  regfile_busy_table #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_busy_table (
    .clk        (Clk),
    .reset      (Reset),
    .rsv_addr   (ReserveRegister),
    .rsv_req    (Reserve),
    .wb_addr    (WriteRegister),
    .wb_en      (RegWrite),
    .rsv_accept (ReserveAccept),
    .busy       (busy),
    .busy_count (BusyCount)
  );

  // Data array; entry 0 is only ever cleared, so it stays zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (RegWrite && real_reg(WriteRegister)) begin
      mem_q[WriteRegister] <= WriteData;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_read
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_busy;

    assign addr = ReadRegister[p*ADDR_W +: ADDR_W];

    // Zero-latency read mux; zero register and out-of-range addresses read idle zero.
    always_comb begin
      rd_data = '0;
      rd_busy = 1'b0;
      if (real_reg(addr)) begin
        rd_data = mem_q[addr];
        rd_busy = busy[addr];
      end
`ifdef REGFILE_BYPASS_EN
      if (RegWrite && real_reg(addr) && (addr == WriteRegister)) begin
        rd_data = WriteData;
        rd_busy = ReserveAccept && (ReserveRegister == addr);
      end
`endif
    end

    assign ReadData[p*WIDTH +: WIDTH] = rd_data;
    assign ReadBusy[p]                = rd_busy;
  end

endmodule
